uart_disk_responder: RTL and testbench

Host-side end of the serial disk protocol, implemented in FPGA fabric: consumes the byte stream the CPU-side disk controller sends over UART, services sector writes and reads against a local byte-wide sector store, and captures debug PC/IR snapshots. Sits between an `async_receiver`/`async_transmitter` pair and a single-port synchronous RAM holding the sector image.

---
 rtl/uart_disk_responder.sv | 165 ++++++++++++++++
 tb/tb_uart_disk_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_disk_responder.sv
// Host-side responder for the serial disk protocol: parses write/read/debug packets
// from the UART receiver, services them against a byte-wide sector store.
module uart_disk_responder #(
    parameter int unsigned SECT_BITS   = 7,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [SECT_BITS+8:0] mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    output logic                 busy,
    output logic [15:0]          cur_sect,
    output logic [31:0]          dbg_pc,
    output logic [31:0]          dbg_ir,
    output logic                 dbg_valid,
    output logic                 wr_done,
    output logic                 rd_done,
    output logic                 err_cmd,
    output logic                 timeout
);

    localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_SECT_LO, S_SECT_HI, S_WDATA, S_RD_ADDR, S_RD_SEND, S_DBG
    } state_t;

    state_t        state, state_nxt;
    logic          is_read;
    logic [7:0]    sect_lo;
    logic [8:0]    offset;
    logic [TW-1:0] tmo_cnt;
    logic [63:0]   dbg_sr;
    logic [63:0]   dbg_shift;
    logic [2:0]    dbg_cnt;
    logic          tx_start_p1;
    logic          rd_last_p1;
    logic          tmo_run, tmo_exp, launch, ev_err, ev_wr, ev_dbg;

    assign busy      = (state != S_IDLE);
    assign mem_addr  = {cur_sect[SECT_BITS-1:0], offset};
    assign mem_we    = (state == S_WDATA) && rx_valid;
    assign mem_wdata = mem_we ? rx_data : 8'h00;
    assign dbg_shift = {rx_data, dbg_sr[63:8]};

    always_comb begin
        state_nxt = state;
        tmo_run   = 1'b0;
        tmo_exp   = 1'b0;
        launch    = 1'b0;
        ev_err    = 1'b0;
        ev_wr     = 1'b0;
        ev_dbg    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h01 || rx_data == 8'h02) state_nxt = S_SECT_LO;
                    else if (rx_data == 8'h03)                state_nxt = S_DBG;
                    else                                      ev_err    = 1'b1;
                end
            end
            S_SECT_LO: begin
                tmo_run = 1'b1;
                if (rx_valid) state_nxt = S_SECT_HI;
            end
            S_SECT_HI: begin
                tmo_run = 1'b1;
                if (rx_valid) state_nxt = is_read ? S_RD_ADDR : S_WDATA;
            end
            S_WDATA: begin
                tmo_run = 1'b1;
                if (rx_valid && offset == 9'h1FF) begin
                    ev_wr     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ADDR: state_nxt = S_RD_SEND;
            // tx_busy lags tx_start by a cycle, so the cycle after a launch is masked
            S_RD_SEND: begin
                if (!tx_busy && !tx_start_p1) begin
                    launch    = 1'b1;
                    state_nxt = (offset == 9'h1FF) ? S_IDLE : S_RD_ADDR;
                end
            end
            S_DBG: begin
                tmo_run = 1'b1;
                if (rx_valid && dbg_cnt == 3'd7) begin
                    ev_dbg    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle takes precedence over the timeout
        if (TMO_EN && tmo_run && !rx_valid && tmo_cnt == TMO_LAST) begin
            tmo_exp   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            is_read     <= 1'b0;
            offset      <= 9'd0;
            cur_sect    <= 16'd0;
            tmo_cnt     <= '0;
            dbg_cnt     <= 3'd0;
            tx_start    <= 1'b0;
            tx_start_p1 <= 1'b0;
            rd_last_p1  <= 1'b0;
            tx_data     <= 8'h00;
            dbg_pc      <= 32'd0;
            dbg_ir      <= 32'd0;
            dbg_valid   <= 1'b0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            err_cmd     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            tx_start    <= launch;
            tx_start_p1 <= tx_start;
            rd_last_p1  <= launch && (offset == 9'h1FF);
            rd_done     <= rd_last_p1;
            err_cmd     <= ev_err;
            wr_done     <= ev_wr;
            dbg_valid   <= ev_dbg;
            timeout     <= tmo_exp;
            if (state == S_IDLE && rx_valid) is_read <= (rx_data == 8'h02);
            if (state == S_SECT_HI && rx_valid) begin
                cur_sect <= {rx_data, sect_lo};
                offset   <= 9'd0;
            end
            if (mem_we) offset <= offset + 9'd1;
            if (launch) begin
                tx_data <= mem_rdata;
                offset  <= offset + 9'd1;
            end
            if (state == S_IDLE)                  dbg_cnt <= 3'd0;
            else if (state == S_DBG && rx_valid)  dbg_cnt <= dbg_cnt + 3'd1;
            if (ev_dbg) begin
                dbg_pc <= dbg_shift[31:0];
                dbg_ir <= dbg_shift[63:32];
            end
            if (!tmo_run || rx_valid || state_nxt == S_IDLE) tmo_cnt <= '0;
            else                                              tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_SECT_LO && rx_valid) sect_lo <= rx_data;
        if (state == S_DBG && rx_valid)     dbg_sr  <= dbg_shift;
    end

endmodule

// File: tb/tb_uart_disk_responder.sv
// Directed bench for uart_disk_responder with a sync-read RAM and a UART transmitter busy model.
module tb_uart_disk_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [15:0] cur_sect;
    logic [31:0] dbg_pc, dbg_ir;
    logic        dbg_valid, wr_done, rd_done, err_cmd, timeout;

    int checks = 0;
    int errors = 0;

    uart_disk_responder #(.SECT_BITS(7), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .cur_sect(cur_sect), .dbg_pc(dbg_pc), .dbg_ir(dbg_ir),
        .dbg_valid(dbg_valid), .wr_done(wr_done), .rd_done(rd_done),
        .err_cmd(err_cmd), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Sector store: synchronous read, cleared while reset is held
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    // Transmitter: busy rises one cycle late and holds for 10 cycles
    logic       start_d = 1'b0;
    logic [3:0] busy_cnt = 4'd0;
    assign tx_busy = (busy_cnt != 4'd0);
    always @(posedge clk) begin
        start_d <= tx_start;
        if (start_d)              busy_cnt <= 4'd10;
        else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
    end

    int         cyc = 0;
    int         tx_cnt = 0, we_cnt = 0, wr_cnt = 0, rd_cnt = 0, dbg_cnt = 0, err_cnt = 0, tmo_cnt = 0;
    int         viol = 0, last_start = -100, rd_gap = -1;
    logic [7:0] rd_buf [0:4095];
    always @(negedge clk) begin
        cyc++;
        if (mem_we)    we_cnt++;
        if (wr_done)   wr_cnt++;
        if (dbg_valid) dbg_cnt++;
        if (err_cmd)   err_cnt++;
        if (timeout)   tmo_cnt++;
        if (rd_done) begin
            rd_cnt++;
            rd_gap = cyc - last_start;
        end
        if (tx_start) begin
            if (tx_busy || (cyc - last_start) < 3) viol++;
            if (tx_cnt < 4096) rd_buf[tx_cnt] = tx_data;
            tx_cnt++;
            last_start = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    int n, bad, base, we0;

    initial begin
        repeat (3) tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_mem", {mem_addr, mem_we, mem_wdata}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_sect", cur_sect, 0);
        chk("rst_dbg", {dbg_pc, dbg_ir}, 0);
        chk("rst_pulses", {dbg_valid, wr_done, rd_done, err_cmd, timeout}, 0);
        rst = 1'b0;
        tick();

        // Write sector 5 with k & 0xFF
        send(8'h01); send(8'h05); send(8'h00);
        for (int k = 0; k < 512; k++) send(8'(k));
        chk("wr5_done_pulse", wr_done, 1);
        chk("wr5_busy_low", busy, 0);
        chk("wr5_cur_sect", cur_sect, 16'h0005);
        chk("wr5_we_count", we_cnt, 512);
        bad = 0;
        for (int k = 0; k < 512; k++) if (mem[5*512 + k] !== 8'(k)) bad++;
        chk("wr5_data", bad, 0);
        chk("wr5_no_spill", {mem[5*512 - 1], mem[6*512]}, 0);
        tick();
        chk("wr5_done_once", wr_cnt, 1);

        // Read sector 5 back through the transmitter model
        base = tx_cnt;
        we0  = we_cnt;
        send(8'h02); send(8'h05); send(8'h00);
        n = 0;
        while (rd_cnt == 0 && n < 20000) begin tick(); n++; end
        chk("rd5_finished", (n < 20000), 1);
        repeat (3) tick();
        chk("rd5_start_count", tx_cnt - base, 512);
        bad = 0;
        for (int k = 0; k < 512; k++) if (rd_buf[base + k] !== 8'(k)) bad++;
        chk("rd5_data", bad, 0);
        chk("rd5_done_once", rd_cnt, 1);
        chk("rd5_done_after_last", rd_gap, 1);
        chk("rd5_start_spacing", viol, 0);
        chk("rd5_no_write", we_cnt - we0, 0);
        chk("rd5_busy_low", busy, 0);

        // Debug snapshot
        send(8'h03);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("dbg_valid_pulse", dbg_valid, 1);
        chk("dbg_pc", dbg_pc, 32'h12345678);
        chk("dbg_ir", dbg_ir, 32'hDEADBEEF);
        tick();
        chk("dbg_valid_once", dbg_cnt, 1);

        // Illegal command byte, then a normal write to sector 9
        we0 = we_cnt;
        send(8'h07);
        chk("err_pulse", err_cmd, 1);
        chk("err_idle", busy, 0);
        chk("err_no_write", we_cnt - we0, 0);
        send(8'h01); send(8'h09); send(8'h00);
        for (int k = 0; k < 512; k++) send(8'(255 - k));
        chk("wr9_done_pulse", wr_done, 1);
        bad = 0;
        for (int k = 0; k < 512; k++) if (mem[9*512 + k] !== 8'(255 - k)) bad++;
        chk("wr9_data", bad, 0);

        // Truncated write to sector 2, then silence until the timeout fires
        send(8'h01); send(8'h02); send(8'h00);
        for (int k = 0; k < 100; k++) send(8'(k + 1));
        n = 0;
        while (timeout !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("tmo_cycles", n, 1000);
        chk("tmo_idle", busy, 0);
        bad = 0;
        for (int k = 0; k < 100; k++) if (mem[2*512 + k] !== 8'(k + 1)) bad++;
        chk("tmo_partial_data", bad, 0);
        chk("tmo_no_extra", mem[2*512 + 100], 0);
        chk("tmo_dbg_kept", dbg_pc, 32'h12345678);
        tick();
        chk("tmo_once", tmo_cnt, 1);
        send(8'h03);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hA0); send(8'hB0); send(8'hC0); send(8'hD0);
        chk("tmo_dbg_pc", dbg_pc, 32'h04030201);
        chk("tmo_dbg_ir", dbg_ir, 32'hD0C0B0A0);

        // Sector 0x8003 folds onto sector 3
        send(8'h01); send(8'h03); send(8'h80);
        for (int k = 0; k < 512; k++) send(8'(k) ^ 8'h5A);
        chk("s8003_cur_sect", cur_sect, 16'h8003);
        bad = 0;
        for (int k = 0; k < 512; k++) if (mem[3*512 + k] !== (8'(k) ^ 8'h5A)) bad++;
        chk("s8003_data", bad, 0);

        // Reset in the middle of a read
        base = tx_cnt;
        send(8'h02); send(8'h03); send(8'h80);
        n = 0;
        while (tx_cnt < base + 5 && n < 2000) begin tick(); n++; end
        chk("rd3_started", (n < 2000), 1);
        chk("rd3_data_first", rd_buf[base], 8'h5A);
        chk("rd3_busy_mid", busy, 1);
        #3 rst = 1'b1;
        #2;
        chk("arst_busy", busy, 0);
        chk("arst_tx", {tx_start, tx_data}, 0);
        chk("arst_mem", {mem_addr, mem_we}, 0);
        chk("arst_cur_sect", cur_sect, 0);
        chk("arst_dbg", {dbg_pc, dbg_ir}, 0);
        base = tx_cnt;
        repeat (4) tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("arst_no_more_tx", tx_cnt - base, 0);
        chk("arst_stays_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
